// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned DEF_DIV_DEF = 18;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_if.sv
// Divisor write port: strobe, target channel and new half-period.
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();
  localparam int unsigned IDX_W = ch_idx_w(NUM_CH);

  logic             wr_en;
  logic [IDX_W-1:0] wr_ch;
  logic [CNT_W-1:0] wr_div;

  modport master (output wr_en, output wr_ch, output wr_div);
  modport slave  (input  wr_en, input  wr_ch, input  wr_div);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: up-counter with shadowed divisor applied only at a
// completed half-period, restart on sync/disable.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d, d_eff;
  logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, term;

  always_comb begin
    d_eff  = (act_q == '0) ? CNT_W'(1) : act_q;
    term   = (cnt_q >= d_eff - CNT_W'(1));
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (sync || !en) begin
      // Phase restarts here, so a new divisor can be taken immediately.
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
      if (wr_hit) begin
        act_d = wr_div;
        shd_d = wr_div;
      end else if (pend_q) begin
        act_d = shd_q;
      end
    end else if (term) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = 1'b1;
      pend_d = 1'b0;
      if (wr_hit)      act_d = wr_div;
      else if (pend_q) act_d = shd_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (wr_hit) begin
        shd_d  = wr_div;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt_q  <= '0;
      act_q  <= DEF;
      shd_q  <= DEF;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;
endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable clock dividers sharing one write port.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  clk_div_if.slave          wr,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);
  localparam int unsigned IDX_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] wr_hit;

  // Out-of-range indices match no channel and are dropped.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr.wr_en && (wr.wr_ch == IDX_W'(i))) wr_hit[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en[g]),
      .sync   (sync),
      .wr_hit (wr_hit[g]),
      .wr_div (wr.wr_div),
      .clk_out(clk_out[g]),
      .tick   (tick[g]),
      .pend   (pend[g])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: countdown reference model predicts
// outputs per edge; a monitor compares after each rising edge.
module tb_clk_div_multi;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DEF = 18;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync;
  logic [NCH-1:0] clk_out, tick, pend;

  clk_div_if #(.NUM_CH(NCH), .CNT_W(CW)) wr_if ();

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEF)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .wr     (wr_if),
    .clk_out(clk_out),
    .tick   (tick),
    .pend   (pend)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
    int             edge_no;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_no = 0;

  // Model: edges remaining until the next toggle, plus divisor bookkeeping.
  int m_rem [NCH];
  int m_act [NCH];
  int m_shd [NCH];
  bit m_pend[NCH];
  bit m_clk [NCH];
  bit m_tick[NCH];

  function automatic int deff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic cyc(input bit r, input logic [NCH-1:0] e, input bit s,
                     input bit we, input int wch, input int wdiv);
    exp_t x;
    bit   hit;
    @(negedge clk_in);
    rst          = r;
    en           = e;
    sync         = s;
    wr_if.wr_en  = we;
    wr_if.wr_ch  = wch[IW-1:0];
    wr_if.wr_div = wdiv[CW-1:0];
    edge_no++;
    for (int ch = 0; ch < NCH; ch++) begin
      hit = we && (wch == ch);
      if (!r) begin
        m_act[ch] = DEF; m_shd[ch] = DEF; m_pend[ch] = 0;
        m_clk[ch] = 0;   m_tick[ch] = 0;  m_rem[ch] = deff(DEF);
      end else if (s || !e[ch]) begin
        if (hit) begin
          m_act[ch] = wdiv; m_shd[ch] = wdiv;
        end else if (m_pend[ch]) begin
          m_act[ch] = m_shd[ch];
        end
        m_pend[ch] = 0; m_clk[ch] = 0; m_tick[ch] = 0;
        m_rem[ch] = deff(m_act[ch]);
      end else begin
        m_rem[ch] = m_rem[ch] - 1;
        if (m_rem[ch] <= 0) begin
          m_clk[ch]  = !m_clk[ch];
          m_tick[ch] = 1;
          if (hit) m_act[ch] = wdiv;
          else if (m_pend[ch]) m_act[ch] = m_shd[ch];
          m_pend[ch] = 0;
          m_rem[ch]  = deff(m_act[ch]);
        end else begin
          m_tick[ch] = 0;
          if (hit) begin
            m_shd[ch] = wdiv; m_pend[ch] = 1;
          end
        end
      end
      x.c[ch] = m_clk[ch];
      x.t[ch] = m_tick[ch];
      x.p[ch] = m_pend[ch];
    end
    x.edge_no = edge_no;
    sb.push_back(x);
  endtask

  task automatic run(input logic [NCH-1:0] e, input int n);
    for (int k = 0; k < n; k++) cyc(1, e, 0, 0, 0, 0);
  endtask

  always begin : monitor
    exp_t x;
    @(posedge clk_in);
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      if (clk_out !== x.c) begin
        bad++;
        $display("FAIL clk_out edge=%0d got=%b exp=%b", x.edge_no, clk_out, x.c);
      end
      total++;
      if (tick !== x.t) begin
        bad++;
        $display("FAIL tick edge=%0d got=%b exp=%b", x.edge_no, tick, x.t);
      end
      total++;
      if (pend !== x.p) begin
        bad++;
        $display("FAIL pend edge=%0d got=%b exp=%b", x.edge_no, pend, x.p);
      end
    end
  end

  initial begin
    logic [NCH-1:0] e;
    rst = 1'b0; en = '0; sync = 1'b0;
    wr_if.wr_en = 1'b0; wr_if.wr_ch = '0; wr_if.wr_div = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_rem[ch] = 0; m_act[ch] = 0; m_shd[ch] = 0;
      m_pend[ch] = 0; m_clk[ch] = 0; m_tick[ch] = 0;
    end

    // Reset, then ch0/ch1 at default; ch1 reprogrammed to 5 mid-period.
    cyc(0, '0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0);
    run(3'b011, 7);
    cyc(1, 3'b011, 0, 1, 1, 5);
    run(3'b011, 50);

    // Divisor 0 on a disabled channel, then enable it.
    cyc(1, 3'b000, 0, 1, 2, 0);
    run(3'b100, 20);

    // ch0=3, ch1=4 loaded while disabled, then sync mid-run.
    cyc(1, 3'b100, 0, 1, 0, 3);
    cyc(1, 3'b100, 0, 1, 1, 4);
    run(3'b011, 13);
    cyc(1, 3'b011, 1, 0, 0, 0);
    run(3'b011, 12);

    // Write coinciding with ch0 terminal count, then out-of-range writes.
    for (int k = 0; k < 300 && m_rem[0] != 1; k++) cyc(1, 3'b011, 0, 0, 0, 0);
    cyc(1, 3'b011, 0, 1, 0, 10);
    run(3'b011, 25);
    for (int k = 0; k < 4; k++) cyc(1, 3'b111, 0, 1, 3, 7);
    run(3'b111, 20);

    // One-edge reset mid-period with enables held.
    cyc(0, 3'b111, 0, 0, 0, 0);
    run(3'b111, 40);

    // Randomized traffic.
    e = 3'b111;
    for (int k = 0; k < 3000; k++) begin
      bit r, s, we;
      int wch, wdiv;
      if ($urandom_range(0, 39) == 0) e = NCH'($urandom);
      r    = ($urandom_range(0, 499) != 0);
      s    = ($urandom_range(0, 99) == 0);
      we   = ($urandom_range(0, 7) == 0);
      wch  = $urandom_range(0, 3);
      wdiv = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 8);
      cyc(r, e, s, we, wch, wdiv);
    end

    @(posedge clk_in);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised, multi-channel successor to the fixed 3 us divider. Generates NUM_CH independent divided clocks from clk_in. Each channel has a runtime-programmable half-period, a per-channel enable, a one-cycle tick strobe, and glitch-free divisor updates at terminal count. It sits beside the existing timing logic and feeds bit-timing and timeout blocks that need several slow rates from one system clock.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
CNT_W, 8, width of divisor and counter
DEF_DIV, 18, half-period loaded at reset (18 = 3 us at 6 MHz clk_in)

Ports:
clk_in  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-low reset, sampled on clk_in rising edge
en  in  NUM_CH  per-channel run enable
sync  in  1  restart the phase of all channels
wr_en  in  1  divisor write strobe
wr_ch  in  max(1,$clog2(NUM_CH))  channel index for the write
wr_div  in  CNT_W  new half-period in clk_in cycles
clk_out  out  NUM_CH  divided clocks, 50% duty, period 2*d_eff cycles
tick  out  NUM_CH  one-cycle pulse on every clk_out toggle
pend  out  NUM_CH  shadow divisor written but not yet applied

Behaviour:
- Per-channel state: cnt[CNT_W], div_act, div_shd, pend, clk_out, tick. All are registered.
- Reset (rst=0 at an edge): cnt=0, clk_out=0, tick=0, pend=0, div_act=div_shd=DEF_DIV. Reset has priority over everything, and a reset in mid-period aborts the period with no partial toggle.
- d_eff = (div_act==0) ? 1 : div_act. A divisor of 0 is legal and treated as 1.
- Priority per edge: rst > sync > en=0 > run.
- en=0: next edge gives cnt=0, clk_out=0, tick=0. A pending divisor is applied immediately (div_act=div_shd, pend=0). A write to a disabled channel loads div_act directly and does not set pend.
- run (en=1): if cnt >= d_eff-1, the terminal count fires: cnt=0, clk_out toggles, tick=1, and div_shd is applied if pend (pend=0). Otherwise cnt=cnt+1 and tick=0. Using >= guards against an out-of-range cnt.
- Timing: clk_out first rises on the d_eff-th consecutive edge with en=1. It then toggles every d_eff edges. tick is coincident with each toggle. With d_eff=1, clk_out toggles every cycle and tick stays high.
- sync=1: every channel gets cnt=0, clk_out=0, tick=0, and pending divisors are applied. sync overrides a terminal count in the same cycle. The next period counts from the edge after sync.
- Write (wr_en=1, wr_ch<NUM_CH, channel running): div_shd=wr_div, pend=1. A write while pend=1 overwrites the shadow, so the last write wins.
- Write in the same cycle as that channel's terminal count: bypass, so div_act=wr_div at that edge and pend=0.
- Write with wr_ch>=NUM_CH is ignored and no state changes.
- A divisor change never produces a runt pulse. The new half-period starts only after a completed half-period.
- Arithmetic: cnt wraps only via terminal count and never overflows because d_eff <= 2^CNT_W-1.

Decomposition:
- Package clk_div_pkg: CNT_W default, DEF_DIV, and a channel-index-width function (max(1,$clog2(n))).
- Sub-module clk_div_ch: one channel holding cnt, div_act, div_shd, pend, clk_out and tick. Its inputs are en, sync, a decoded write strobe and wr_div.
- The top, clk_div_multi, decodes wr_ch into per-channel strobes and generate-instantiates NUM_CH copies of clk_div_ch. Expected size is about 150-250 RTL lines.

Test Plan:
- Reset, then en=4'b0001 from edge 0, defaults -> clk_out[0] rises at edge 18 and falls at 36 (period 36). tick[0] pulses at 18, 36, 54. Other channels stay 0.
- Ch1 running at 18; write wr_div=5 at edge 7 -> pend[1]=1 until edge 18 (toggle at 18, still using 18). Next toggles at 23, 28. pend[1]=0 from 18.
- Write wr_div=0 to ch2 while disabled, then enable -> clk_out[2] toggles every cycle, tick[2] constant 1, pend[2] never set.
- Two channels at divisors 3 and 4, sync pulsed at an arbitrary edge -> both clk_out=0 next edge. First toggles at sync+3 and sync+4.
- Write to ch0 coinciding with its terminal count (wr_div=10) -> toggle at that edge, next toggle 10 edges later, pend[0] stays 0. Write with wr_ch=NUM_CH -> no change.
- rst=0 for one edge mid-period with en held high -> all outputs 0 next edge, divisors back to 18, first toggle 18 edges after rst releases.
